// File: rtl/calc_seq_core_if.sv
// Keypad-side and display-side signal bundle for calc_seq_core.
// Latency: none, wires only.
// Backpressure: none; strobes are single-cycle and are never stalled.
interface calc_seq_core_if #(
    parameter int WIDTH = 8
);
    logic             clear;
    logic             key_valid;
    logic [WIDTH-1:0] key_val;
    logic             op_valid;
    logic [1:0]       op;
    logic [WIDTH-1:0] disp_val;
    logic             disp_sel;
    logic             result_valid;
    logic             cout;
    logic             zero;
    logic             busy;
    logic             err;
    logic [2:0]       state;

    // keypad decoder / testbench side
    modport master (
        output clear, key_valid, key_val, op_valid, op,
        input  disp_val, disp_sel, result_valid, cout, zero, busy, err, state
    );

    // calculator core side
    modport slave (
        input  clear, key_valid, key_val, op_valid, op,
        output disp_val, disp_sel, result_valid, cout, zero, busy, err, state
    );
endinterface

// File: rtl/calc_seq_core.sv
// Sequencing calculator core: A/op/B entry FSM, ADD/SUB/ADC, optional MUL (CALC_MUL_EN), result chaining.
// Latency: single-cycle ops write R one edge after B is strobed; MUL takes WIDTH S_EXEC cycles.
// Backpressure: none; strobes arriving in S_EXEC or in S_A (op) are dropped, illegal ops pulse err.
module calc_seq_core #(
    parameter int WIDTH = 8
) (
    input  logic         clock,
    input  logic         reset,
    calc_seq_core_if.slave bus
);
    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_OP   = 3'd1,
        S_B    = 3'd2,
        S_EXEC = 3'd3,
        S_RES  = 3'd4
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_ADC = 2'b10;
    localparam logic [1:0] OP_MUL = 2'b11;

    state_t           st, st_nx;
    logic [WIDTH-1:0] a_q, b_q, r_q;
    logic [1:0]       opc_q;
    logic             cout_q, zero_q, rv_q, err_q;

    logic             op_legal, exec_done;
    logic             ld_a_key, ld_a_res, ld_b, ld_op, wr_r, rej;
    logic [WIDTH-1:0] res_r;
    logic             res_c;
    logic [WIDTH:0]   sum;

`ifdef CALC_MUL_EN
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    logic [2*WIDTH-1:0] acc_q, acc_nx;
    logic [CW-1:0]      cnt_q;

    assign op_legal  = 1'b1;
    // shift-add: add A<<i when multiplier bit i is set
    assign acc_nx    = acc_q + (b_q[cnt_q] ? ({{WIDTH{1'b0}}, a_q} << cnt_q) : '0);
    assign exec_done = (opc_q != OP_MUL) || (cnt_q == CW'(WIDTH - 1));
`else
    assign op_legal  = (bus.op != OP_MUL);
    assign exec_done = 1'b1;
`endif

    // state register; clear behaves like a synchronous reset
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)          st <= S_A;
        else if (bus.clear)  st <= S_A;
        else                 st <= st_nx;
    end

    // next-state and register-load decisions; op_valid has priority except in S_B
    always_comb begin
        st_nx    = st;
        ld_a_key = 1'b0;
        ld_a_res = 1'b0;
        ld_b     = 1'b0;
        ld_op    = 1'b0;
        wr_r     = 1'b0;
        rej      = 1'b0;
        case (st)
            S_A: begin
                if (bus.key_valid) begin
                    ld_a_key = 1'b1;
                    st_nx    = S_OP;
                end
            end
            S_OP: begin
                if (bus.op_valid) begin
                    if (op_legal) begin
                        ld_op = 1'b1;
                        st_nx = S_B;
                    end else begin
                        rej = 1'b1;
                    end
                end else if (bus.key_valid) begin
                    ld_a_key = 1'b1;
                end
            end
            S_B: begin
                if (bus.key_valid) begin
                    ld_b  = 1'b1;
                    st_nx = S_EXEC;
                end else if (bus.op_valid) begin
                    if (op_legal) ld_op = 1'b1;
                    else          rej   = 1'b1;
                end
            end
            S_EXEC: begin
                if (exec_done) begin
                    wr_r  = 1'b1;
                    st_nx = S_RES;
                end
            end
            S_RES: begin
                if (bus.op_valid) begin
                    if (op_legal) begin
                        ld_a_res = 1'b1;
                        ld_op    = 1'b1;
                        st_nx    = S_B;
                    end else begin
                        rej = 1'b1;
                    end
                end else if (bus.key_valid) begin
                    ld_a_key = 1'b1;
                    st_nx    = S_OP;
                end
            end
            default: st_nx = S_A;
        endcase
    end

    // result and flag for the latched opcode
    always_comb begin
        sum   = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, (opc_q == OP_ADC) & cout_q};
        res_r = sum[WIDTH-1:0];
        res_c = sum[WIDTH];
        if (opc_q == OP_SUB) begin
            res_r = a_q - b_q;
            res_c = (a_q < b_q);
        end
`ifdef CALC_MUL_EN
        if (opc_q == OP_MUL) begin
            res_r = acc_nx[WIDTH-1:0];
            res_c = |acc_nx[2*WIDTH-1:WIDTH];
        end
`endif
    end

    // operand, opcode, result and pulse registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            a_q <= '0; b_q <= '0; r_q <= '0; opc_q <= '0;
            cout_q <= 1'b0; zero_q <= 1'b0; rv_q <= 1'b0; err_q <= 1'b0;
        end else if (bus.clear) begin
            a_q <= '0; b_q <= '0; r_q <= '0; opc_q <= '0;
            cout_q <= 1'b0; zero_q <= 1'b0; rv_q <= 1'b0; err_q <= 1'b0;
        end else begin
            rv_q  <= wr_r;
            err_q <= rej;
            if (ld_a_key)      a_q <= bus.key_val;
            else if (ld_a_res) a_q <= r_q;
            if (ld_b)  b_q   <= bus.key_val;
            if (ld_op) opc_q <= bus.op;
            if (wr_r) begin
                r_q    <= res_r;
                cout_q <= res_c;
                zero_q <= (res_r == '0);
            end
        end
    end

`ifdef CALC_MUL_EN
    // multiply accumulator and bit counter, restarted whenever B is loaded
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else if (bus.clear || ld_b) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else if (st == S_EXEC && opc_q == OP_MUL) begin
            acc_q <= acc_nx;
            cnt_q <= cnt_q + 1'b1;
        end
    end
`endif

    assign bus.disp_val     = (st == S_RES) ? r_q :
                              ((st == S_B) || (st == S_EXEC)) ? b_q : a_q;
    assign bus.disp_sel     = (st == S_RES);
    assign bus.result_valid = rv_q;
    assign bus.cout         = cout_q;
    assign bus.zero         = zero_q;
    assign bus.busy         = (st == S_EXEC);
    assign bus.err          = err_q;
    assign bus.state        = st;
endmodule

// File: tb/tb_calc_seq_core.sv
// Directed-vector bench for calc_seq_core at WIDTH=8.
// Latency: checks sample outputs 1 time unit after the active clock edge.
// Backpressure: none; strobes are driven for exactly one cycle.
module tb_calc_seq_core;
    logic clock;
    logic reset;
    int   n_vec;
    int   n_err;

    calc_seq_core_if #(.WIDTH(8)) bus ();

    calc_seq_core #(.WIDTH(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic key(input logic [7:0] v);
        bus.key_valid = 1'b1;
        bus.key_val   = v;
        tick();
        bus.key_valid = 1'b0;
    endtask

    task automatic opx(input logic [1:0] o);
        bus.op_valid = 1'b1;
        bus.op       = o;
        tick();
        bus.op_valid = 1'b0;
    endtask

    initial begin
        int cyc;
        n_vec = 0;
        n_err = 0;
        reset = 1'b0;
        bus.clear = 1'b0; bus.key_valid = 1'b0; bus.key_val = '0;
        bus.op_valid = 1'b0; bus.op = '0;
        #12;
        chk("rst_state", bus.state, 0);
        chk("rst_disp", bus.disp_val, 0);
        chk("rst_sel", bus.disp_sel, 0);
        chk("rst_rv", bus.result_valid, 0);
        chk("rst_flags", {bus.cout, bus.zero, bus.busy, bus.err}, 0);
        @(negedge clock) reset = 1'b1;
        tick();

        // ADD 100 + 200 = 300 -> 0x2C carry out
        key(8'd100);
        chk("a_state", bus.state, 1);
        chk("a_disp", bus.disp_val, 100);
        opx(2'b00);
        chk("op_state", bus.state, 2);
        key(8'd200);
        chk("exec_state", bus.state, 3);
        chk("exec_busy", bus.busy, 1);
        chk("exec_rv", bus.result_valid, 0);
        tick();
        chk("add_state", bus.state, 4);
        chk("add_rv", bus.result_valid, 1);
        chk("add_r", bus.disp_val, 8'h2C);
        chk("add_cz", {bus.cout, bus.zero}, 2'b10);
        chk("add_sel", bus.disp_sel, 1);
        chk("add_busy", bus.busy, 0);
        tick();
        chk("add_rv_off", bus.result_valid, 0);

        // chain: ADC with previous carry, 0x2C + 1 + 1
        opx(2'b10);
        chk("chain_state", bus.state, 2);
        chk("chain_sel", bus.disp_sel, 0);
        key(8'd1);
        tick();
        chk("adc_r", bus.disp_val, 8'h2E);
        chk("adc_c", bus.cout, 0);

        // SUB with borrow, then SUB to zero
        key(8'd5); opx(2'b01); key(8'd9); tick();
        chk("sub_r", bus.disp_val, 8'hFC);
        chk("sub_cz", {bus.cout, bus.zero}, 2'b10);
        key(8'd9); opx(2'b01); key(8'd9); tick();
        chk("sub0_r", bus.disp_val, 0);
        chk("sub0_cz", {bus.cout, bus.zero}, 2'b01);

        // key and op together in S_OP: op wins, A keeps 0x33
        key(8'h33);
        chk("prio_a", bus.disp_val, 8'h33);
        bus.key_valid = 1'b1; bus.key_val = 8'h44;
        bus.op_valid = 1'b1;  bus.op = 2'b00;
        tick();
        bus.key_valid = 1'b0; bus.op_valid = 1'b0;
        chk("prio_state", bus.state, 2);
        key(8'd1); tick();
        chk("prio_r", bus.disp_val, 8'h34);

`ifdef CALC_MUL_EN
        // 15 x 17 = 255, eight busy cycles
        key(8'd15); opx(2'b11); key(8'd17);
        cyc = 0;
        while (bus.busy && cyc < 20) begin
            cyc++;
            tick();
        end
        chk("mul_busy_cycles", cyc, 8);
        chk("mul_state", bus.state, 4);
        chk("mul_r", bus.disp_val, 255);
        chk("mul_cz", {bus.cout, bus.zero}, 2'b00);
        chk("mul_rv", bus.result_valid, 1);
        tick();
        chk("mul_rv_off", bus.result_valid, 0);
        // 16 x 16 = 256 -> low byte 0, overflow
        key(8'd16); opx(2'b11); key(8'd16);
        cyc = 0;
        while (bus.busy && cyc < 20) begin
            cyc++;
            tick();
        end
        chk("mul2_r", bus.disp_val, 0);
        chk("mul2_cz", {bus.cout, bus.zero}, 2'b11);
`else
        // op 11 rejected without multiplier
        key(8'd3);
        opx(2'b11);
        chk("ill_err", bus.err, 1);
        chk("ill_state", bus.state, 1);
        chk("ill_a", bus.disp_val, 3);
        tick();
        chk("ill_err_off", bus.err, 0);
        opx(2'b00);
        chk("ill_next_state", bus.state, 2);
        key(8'd4); tick();
        chk("ill_next_r", bus.disp_val, 7);
`endif

        // clear while executing: would produce 0xF0+0x20 with carry
        key(8'hF0); opx(2'b00); key(8'h20);
        chk("clr_busy", bus.busy, 1);
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        chk("clr_state", bus.state, 0);
        chk("clr_disp", bus.disp_val, 0);
        chk("clr_flags", {bus.result_valid, bus.cout, bus.zero, bus.busy, bus.disp_sel}, 0);
        tick();
        chk("clr_rv", bus.result_valid, 0);

        // asynchronous reset while executing
`ifdef CALC_MUL_EN
        key(8'd15); opx(2'b11); key(8'd17); tick(); tick();
`else
        key(8'h80); opx(2'b00); key(8'h80);
`endif
        chk("ar_busy", bus.busy, 1);
        #2 reset = 1'b0;
        #1;
        chk("ar_state", bus.state, 0);
        chk("ar_disp", bus.disp_val, 0);
        chk("ar_busy_off", bus.busy, 0);
        @(negedge clock) reset = 1'b1;
        tick();
        tick();
        chk("ar_rv", bus.result_valid, 0);
        chk("ar_cout", bus.cout, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/calc_seq_core.md
# calc_seq_core

Parametrised sequencing arithmetic core for the keypad calculator. It replaces the separate control unit, A/B/R register arithmetic unit and input/result display mux with one FSM-driven block. It accepts operand and operator strobes from the keypad decoder, computes ADD/SUB/ADC (and an optional iterative MUL) and supports result chaining. It drives a WIDTH-bit display value to the seven-segment output stage.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits (≥ 2)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- clear  in  1  synchronous clear; same cycle effect as reset, but registered
- key_valid  in  1  one-cycle strobe: key_val holds a completed operand
- key_val  in  WIDTH  operand from keypad decoder
- op_valid  in  1  one-cycle strobe: op holds an operator
- op  in  2  00 ADD, 01 SUB, 10 ADC, 11 MUL (only with CALC_MUL_EN)
- disp_val  out  WIDTH  value for the display stage
- disp_sel  out  1  1 = disp_val is a result, 0 = operand entry
- result_valid  out  1  one-cycle pulse when R/flags update
- cout  out  1  carry/borrow/overflow flag of the last result
- zero  out  1  last result == 0
- busy  out  1  high in S_EXEC
- err  out  1  one-cycle pulse on rejected operator
- state  out  3  S_A=0, S_OP=1, S_B=2, S_EXEC=3, S_RES=4

## Operation
- Registers: A, B, R (WIDTH), opcode (2), cout, zero, and the MUL iteration counter.
- S_A: key_valid loads A ← key_val, then → S_OP. op_valid is ignored.
- S_OP: op_valid with a legal op latches the opcode, then → S_B. If key_valid is also high, op_valid wins and key_valid is dropped. key_valid alone reloads A and the state stays S_OP.
- S_B: key_valid loads B, then → S_EXEC. op_valid alone re-latches the opcode.
- S_EXEC: all strobes are ignored.
  - ADD/SUB/ADC: one cycle, then → S_RES.
  - MUL: shift-add, one multiplier bit per cycle over WIDTH cycles, then → S_RES.
- S_RES:
  - op_valid (legal): A ← R, opcode latched, → S_B (chaining).
  - key_valid: A ← key_val, → S_OP.
  - If both strobes are high, op_valid wins.
- Arithmetic is unsigned, modulo 2^WIDTH:
  - ADD: {cout,R} = A+B.
  - SUB: R = A−B; cout = 1 iff A<B (borrow).
  - ADC: {cout,R} = A+B+cout_prev.
  - MUL: R = low WIDTH bits of A·B; cout = 1 iff the high WIDTH bits ≠ 0.
- zero = (R==0), updated together with R.
- Display:
  - disp_val = A in S_A/S_OP, B in S_B/S_EXEC, R in S_RES.
  - disp_sel = (state==S_RES).
- Illegal op (11 without the macro): err pulses, and the state, opcode and registers are unchanged.
- clear, valid in any state including S_EXEC: aborts any operation; all registers and flags → 0; state → S_A. clear overrides all strobes.

## Timing
- Reset (async assert, sync release) and clear:
  - All registers 0; state=S_A.
  - disp_val=0, disp_sel=0, result_valid=0, cout=0, zero=0, busy=0, err=0.
- Strobes are sampled on the rising edge.
  - The state changes on the edge after the strobe.
  - The display reflects the new register on the following cycle.
- Single-cycle ops: key_valid for B at edge n → S_EXEC after n. At edge n+1, R/flags are written and state=S_RES. result_valid is high in cycle n+1..n+2.
- MUL: S_EXEC lasts exactly WIDTH cycles. R/flags are written on the WIDTH-th S_EXEC edge, and result_valid pulses once. busy is high throughout S_EXEC.
- err is high for exactly one cycle after the rejecting edge.
- Async reset mid-MUL: the partial product is discarded; no result_valid.

## Configuration
- CALC_MUL_EN defined: op 11 = iterative MUL; counter and shift-add datapath are instantiated.
- CALC_MUL_EN undefined: op 11 is illegal and rejected with an err pulse; no multiplier logic. S_EXEC is always one cycle.

## Test plan
- WIDTH=8, ADD: A=100, B=200 → R=0x2C, cout=1, zero=0; result_valid is a single one-cycle pulse two edges after B's strobe.
- SUB: A=5, B=9 → R=0xFC, cout=1. SUB: A=9, B=9 → R=0, zero=1, cout=0.
- Chaining and ADC:
  - After 100+200 (cout=1), op_valid ADC in S_RES → A=0x2C, state S_B.
  - B=1 → R=0x2E, cout=0.
  - disp_sel is 1 only in S_RES.
- MUL (macro on): 15×17 → R=255, cout=0, busy for exactly 8 cycles. 16×16 → R=0, cout=1, zero=1.
- MUL macro off: op=11 in S_OP → err one cycle; state stays S_OP; a following op=00 is accepted.
- Abort and priority:
  - clear during S_EXEC → all outputs 0, state S_A, no result_valid.
  - key_valid+op_valid together in S_OP → op accepted, A unchanged.
  - reset low mid-MUL → immediate reset values.
